// File: rtl/mac_pkg.sv
// Shared constants and saturation helpers for the paired-operand MAC.
package mac_pkg;

  localparam int unsigned OvfWrap      = 0;
  localparam int unsigned OvfSaturate  = 1;
  localparam int unsigned SignUnsigned = 0;
  localparam int unsigned SignTwos     = 1;
  localparam int unsigned MaxAccW      = 64;

  // Results are MaxAccW wide; callers keep the low acc_w bits.
  function automatic logic [MaxAccW-1:0] sat_max(int unsigned acc_w, bit is_signed);
    logic [MaxAccW-1:0] one;
    one = MaxAccW'(1);
    return (one << (is_signed ? acc_w - 1 : acc_w)) - one;
  endfunction

  function automatic logic [MaxAccW-1:0] sat_min(int unsigned acc_w, bit is_signed);
    logic [MaxAccW-1:0] one;
    one = MaxAccW'(1);
    return is_signed ? (one << (acc_w - 1)) : '0;
  endfunction

endpackage

// File: rtl/mac_pair_acc_if.sv
// Operand streams, clear control and accumulator outputs of mac_pair_acc.
interface mac_pair_acc_if #(
  parameter int unsigned A_W   = 4,
  parameter int unsigned B_W   = 4,
  parameter int unsigned ACC_W = 11,
  parameter int unsigned CNT_W = 8
);
  logic [A_W-1:0]   in_a;
  logic             in_valid_a;
  logic             in_ready_a;
  logic [B_W-1:0]   in_b;
  logic             in_valid_b;
  logic             in_ready_b;
  logic             clear;
  logic [ACC_W-1:0] mac_out;
  logic             out_valid;
  logic             acc_ovf;
  logic [CNT_W-1:0] prod_cnt;

  modport slave (
    input  in_a, in_valid_a, in_b, in_valid_b, clear,
    output in_ready_a, in_ready_b, mac_out, out_valid, acc_ovf, prod_cnt
  );

  modport master (
    output in_a, in_valid_a, in_b, in_valid_b, clear,
    input  in_ready_a, in_ready_b, mac_out, out_valid, acc_ovf, prod_cnt
  );
endinterface

// File: rtl/mac_operand_fifo.sv
// Small synchronous operand FIFO with registered ready/empty; ready is low during reset.
module mac_operand_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             ready_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    cnt_q, cnt_d;
  logic             ready_q, ready_d, empty_q, empty_d;
  logic             push, pop;

  // Ready reflects only fullness, so a full FIFO refuses a push even while popping.
  assign push = push_i & ready_q;
  assign pop  = pop_i & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PtrW + 1)'(1);
      2'b01:   cnt_d = cnt_q - (PtrW + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
    ready_d = (cnt_d != FullCnt);
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign ready_o = ready_q;
  assign empty_o = empty_q;
endmodule

// File: rtl/mac_pair_acc.sv
// Pairs A/B operands in arrival order, registers their product, then accumulates it
// with wrap or saturate overflow handling.
module mac_pair_acc
  import mac_pkg::*;
#(
  parameter int unsigned A_W      = 4,
  parameter int unsigned B_W      = 4,
  parameter int unsigned ACC_W    = 11,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned SIGNED   = SignUnsigned,
  parameter int unsigned SATURATE = OvfWrap,
  parameter int unsigned CNT_W    = 8
) (
  input logic            clk,
  input logic            reset,
  mac_pair_acc_if.slave  bus
);
  localparam int unsigned PW = A_W + B_W;
  localparam logic [MaxAccW-1:0] SatMaxW = sat_max(ACC_W, SIGNED == SignTwos);
  localparam logic [MaxAccW-1:0] SatMinW = sat_min(ACC_W, SIGNED == SignTwos);

  if (ACC_W < PW) begin : g_bad_acc_w
    $error("ACC_W must be >= A_W + B_W");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end

  logic [A_W-1:0]   a_data;
  logic [B_W-1:0]   b_data;
  logic             a_empty, b_empty, pair_pop;
  logic [PW-1:0]    a_ext, b_ext, prod_full;
  logic [ACC_W-1:0] prod_q, prod_d, acc_q, acc_d;
  logic             prod_vld_q, out_valid_q, out_valid_d, ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W:0]   sum;
  logic             step_ovf;

  mac_operand_fifo #(.WIDTH(A_W), .DEPTH(DEPTH)) u_fifo_a (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (bus.in_valid_a),
    .wdata_i (bus.in_a),
    .ready_o (bus.in_ready_a),
    .pop_i   (pair_pop),
    .rdata_o (a_data),
    .empty_o (a_empty)
  );

  mac_operand_fifo #(.WIDTH(B_W), .DEPTH(DEPTH)) u_fifo_b (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (bus.in_valid_b),
    .wdata_i (bus.in_b),
    .ready_o (bus.in_ready_b),
    .pop_i   (pair_pop),
    .rdata_o (b_data),
    .empty_o (b_empty)
  );

  assign pair_pop = ~a_empty & ~b_empty;

  // Operands extended to the full product width so a PW-bit multiply is exact in both modes.
  always_comb begin
    if (SIGNED == SignTwos) begin
      a_ext  = PW'($signed(a_data));
      b_ext  = PW'($signed(b_data));
    end else begin
      a_ext  = PW'(a_data);
      b_ext  = PW'(b_data);
    end
    prod_full = a_ext * b_ext;
    prod_d    = (SIGNED == SignTwos) ? ACC_W'($signed(prod_full)) : ACC_W'(prod_full);
  end

  always_comb begin
    sum = {1'b0, acc_q} + {1'b0, prod_q};
    if (SIGNED == SignTwos) begin
      step_ovf = (acc_q[ACC_W-1] == prod_q[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
    end else begin
      step_ovf = sum[ACC_W];
    end

    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    if (bus.clear) begin
      acc_d       = prod_vld_q ? prod_q : '0;
      cnt_d       = prod_vld_q ? CNT_W'(1) : '0;
      ovf_d       = 1'b0;
      out_valid_d = prod_vld_q;
    end else if (prod_vld_q) begin
      acc_d = sum[ACC_W-1:0];
      if (step_ovf && SATURATE == OvfSaturate) begin
        // Signed overflow only happens with like signs, so acc sign picks the rail.
        acc_d = (SIGNED == SignTwos && acc_q[ACC_W-1]) ? SatMinW[ACC_W-1:0]
                                                      : SatMaxW[ACC_W-1:0];
      end
      ovf_d       = ovf_q | step_ovf;
      cnt_d       = cnt_q + CNT_W'(1);
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod_q      <= '0;
      prod_vld_q  <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      prod_q      <= prod_d;
      prod_vld_q  <= pair_pop;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.mac_out   = acc_q;
  assign bus.out_valid = out_valid_q;
  assign bus.acc_ovf   = ovf_q;
  assign bus.prod_cnt  = cnt_q;
endmodule

// File: tb/tb_mac_pair_acc.sv
// Directed bench for mac_pair_acc: default, saturating and signed instances share stimulus.
module tb_mac_pair_acc;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] in_a = '0, in_b = '0;
  logic       va = 1'b0, vb = 1'b0, clr = 1'b0;
  int         n_chk = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  mac_pair_acc_if #(.A_W(4), .B_W(4), .ACC_W(11), .CNT_W(8)) bus_def ();
  mac_pair_acc_if #(.A_W(4), .B_W(4), .ACC_W(11), .CNT_W(8)) bus_sat ();
  mac_pair_acc_if #(.A_W(4), .B_W(4), .ACC_W(11), .CNT_W(8)) bus_sgn ();

  assign bus_def.in_a = in_a;  assign bus_def.in_b = in_b;  assign bus_def.clear = clr;
  assign bus_def.in_valid_a = va;  assign bus_def.in_valid_b = vb;
  assign bus_sat.in_a = in_a;  assign bus_sat.in_b = in_b;  assign bus_sat.clear = clr;
  assign bus_sat.in_valid_a = va;  assign bus_sat.in_valid_b = vb;
  assign bus_sgn.in_a = in_a;  assign bus_sgn.in_b = in_b;  assign bus_sgn.clear = clr;
  assign bus_sgn.in_valid_a = va;  assign bus_sgn.in_valid_b = vb;

  mac_pair_acc #(.A_W(4), .B_W(4), .ACC_W(11), .DEPTH(2), .SIGNED(0), .SATURATE(0),
                 .CNT_W(8)) u_def (.clk(clk), .reset(reset), .bus(bus_def));
  mac_pair_acc #(.A_W(4), .B_W(4), .ACC_W(11), .DEPTH(2), .SIGNED(0), .SATURATE(1),
                 .CNT_W(8)) u_sat (.clk(clk), .reset(reset), .bus(bus_sat));
  mac_pair_acc #(.A_W(4), .B_W(4), .ACC_W(11), .DEPTH(2), .SIGNED(1), .SATURATE(0),
                 .CNT_W(8)) u_sgn (.clk(clk), .reset(reset), .bus(bus_sgn));

  typedef struct {
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    int         mac;
    int         cnt;
    int         ovf;
    int         smac;
    int         sovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Async reset: outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; va = 1'b0; vb = 1'b0; clr = 1'b0;
    #1;
    chk("rst_mac", int'(bus_def.mac_out), 0);
    chk("rst_valid", int'(bus_def.out_valid), 0);
    chk("rst_ovf", int'(bus_def.acc_ovf), 0);
    chk("rst_cnt", int'(bus_def.prod_cnt), 0);
    chk("rst_ready", int'(bus_def.in_ready_a | bus_def.in_ready_b), 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("ready_before_edge", int'(bus_def.in_ready_a), 0);
    @(negedge clk);
    chk("ready_after_rst", int'(bus_def.in_ready_a & bus_def.in_ready_b), 1);
  endtask

  // Push one simultaneous pair at edge k; returns at the negedge after k+2.
  task automatic push_pair(input logic [3:0] a, input logic [3:0] b);
    for (int i = 0; i < 20 && !(bus_def.in_ready_a && bus_def.in_ready_b); i++) @(negedge clk);
    if (!(bus_def.in_ready_a && bus_def.in_ready_b)) chk("ready_timeout", 0, 1);
    in_a = a; in_b = b; va = 1'b1; vb = 1'b1;
    step();
    va = 1'b0; vb = 1'b0;
    chk("lat_k", int'(bus_def.out_valid), 0);
    step();
    chk("lat_k1", int'(bus_def.out_valid), 0);
    step();
    chk("lat_k2", int'(bus_def.out_valid), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp2[3] = '{2, 20, 245};
    int ta[3]   = '{2, 2, 15};
    int tbv[3]  = '{1, 9, 15};

    vecs.push_back('{1'b1, 4'd2, 4'd1, 2, 1, 0, 2, 0});
    vecs.push_back('{1'b0, 4'd2, 4'd9, 20, 2, 0, 20, 0});
    vecs.push_back('{1'b0, 4'd15, 4'd15, 245, 3, 0, 245, 0});
    vecs.push_back('{1'b1, 4'd15, 4'd15, 225, 1, 0, 225, 0});
    for (int i = 2; i <= 9; i++) vecs.push_back('{1'b0, 4'd15, 4'd15, 225 * i, i, 0, 225 * i, 0});
    vecs.push_back('{1'b0, 4'd15, 4'd1, 2040, 10, 0, 2040, 0});
    vecs.push_back('{1'b0, 4'd15, 4'd15, 217, 11, 1, 2047, 1});
    vecs.push_back('{1'b0, 4'd1, 4'd1, 218, 12, 1, 2047, 1});

    // a=6 at edge k, b=1 at edge k+2 -> result after edge k+4, single pulse.
    do_reset();
    in_a = 4'd6; va = 1'b1;
    step();
    va = 1'b0;
    step();
    in_b = 4'd1; vb = 1'b1;
    step();
    vb = 1'b0;
    chk("t1_valid_k2", int'(bus_def.out_valid), 0);
    step();
    chk("t1_valid_k3", int'(bus_def.out_valid), 0);
    step();
    chk("t1_valid_k4", int'(bus_def.out_valid), 1);
    chk("t1_mac", int'(bus_def.mac_out), 6);
    chk("t1_cnt", int'(bus_def.prod_cnt), 1);
    step();
    chk("t1_pulse_end", int'(bus_def.out_valid), 0);
    chk("t1_mac_hold", int'(bus_def.mac_out), 6);

    // Back-to-back pairs, one per cycle.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i >= 3) begin
        chk("t2_valid", int'(bus_def.out_valid), 1);
        chk("t2_mac", int'(bus_def.mac_out), exp2[i-3]);
      end
      if (i < 3) begin
        chk("t2_ready", int'(bus_def.in_ready_a & bus_def.in_ready_b), 1);
        in_a = 4'(ta[i]); in_b = 4'(tbv[i]); va = 1'b1; vb = 1'b1;
      end else begin
        va = 1'b0; vb = 1'b0;
      end
      step();
    end
    chk("t2_cnt", int'(bus_def.prod_cnt), 3);

    // Only A stream: FIFO fills and ready drops; B then drains two pairs.
    do_reset();
    in_a = 4'd3; va = 1'b1;
    step();
    chk("t3_ready_after1", int'(bus_def.in_ready_a), 1);
    in_a = 4'd5;
    step();
    chk("t3_ready_after2", int'(bus_def.in_ready_a), 0);
    in_a = 4'd7;
    step();
    step();
    chk("t3_ready_held", int'(bus_def.in_ready_a), 0);
    chk("t3_no_acc", int'(bus_def.out_valid), 0);
    in_b = 4'd1; vb = 1'b1;
    step();
    step();
    vb = 1'b0;
    chk("t3_ready_recover", int'(bus_def.in_ready_a), 1);
    step();
    va = 1'b0;
    chk("t3_first", int'(bus_def.mac_out), 3);
    step();
    chk("t3_sum", int'(bus_def.mac_out), 8);
    chk("t3_cnt", int'(bus_def.prod_cnt), 2);

    // Reset with a=7 still queued: the operand must be lost.
    do_reset();
    in_b = 4'd1; vb = 1'b1;
    step();
    vb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t7_no_pair", int'(bus_def.out_valid), 0);
      step();
    end
    chk("t7_mac", int'(bus_def.mac_out), 0);

    // Table: running accumulation, wrap vs saturate.
    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      push_pair(vecs[i].a, vecs[i].b);
      chk($sformatf("v%0d_mac", i), int'(bus_def.mac_out), vecs[i].mac);
      chk($sformatf("v%0d_cnt", i), int'(bus_def.prod_cnt), vecs[i].cnt);
      chk($sformatf("v%0d_ovf", i), int'(bus_def.acc_ovf), vecs[i].ovf);
      chk($sformatf("v%0d_sat_mac", i), int'(bus_sat.mac_out), vecs[i].smac);
      chk($sformatf("v%0d_sat_ovf", i), int'(bus_sat.acc_ovf), vecs[i].sovf);
    end

    // Clear on the same edge the product (5,1) lands; ovf was set beforehand.
    in_a = 4'd5; in_b = 4'd1; va = 1'b1; vb = 1'b1;
    step();
    va = 1'b0; vb = 1'b0;
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t6_valid", int'(bus_def.out_valid), 1);
    chk("t6_mac", int'(bus_def.mac_out), 5);
    chk("t6_cnt", int'(bus_def.prod_cnt), 1);
    chk("t6_ovf", int'(bus_def.acc_ovf), 0);
    chk("t6_sat_mac", int'(bus_sat.mac_out), 5);
    chk("t6_sat_ovf", int'(bus_sat.acc_ovf), 0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_valid", int'(bus_def.out_valid), 0);
    chk("clr_mac", int'(bus_def.mac_out), 0);
    chk("clr_cnt", int'(bus_def.prod_cnt), 0);

    // Signed: -8*7 = -56, then -8*-8 = 64.
    do_reset();
    push_pair(4'b1000, 4'd7);
    chk("t5_sgn_mac1", int'(bus_sgn.mac_out), 'h7C8);
    chk("t5_def_mac1", int'(bus_def.mac_out), 56);
    push_pair(4'b1000, 4'b1000);
    chk("t5_sgn_mac2", int'(bus_sgn.mac_out), 8);
    chk("t5_sgn_ovf", int'(bus_sgn.acc_ovf), 0);
    chk("t5_sgn_cnt", int'(bus_sgn.prod_cnt), 2);
    chk("t5_def_mac2", int'(bus_def.mac_out), 120);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
